// File: rtl/edp_mdseq_if.sv
// Control bundle between EBOX CTL and the multiply/divide step sequencer.
// Optional stats signals are present only when EDP_MDSEQ_STATS_EN is defined.
interface edp_mdseq_if #(
  parameter int STEPW = 6
);
  // start/op/steps are sampled only while busy is low; while busy is high the
  // sequencer owns the EDP controls, and done marks its last busy cycle.
  logic             start;
  logic             op;
  logic [STEPW-1:0] steps;
  logic             abort;
  logic             mq35;
  logic             ad_sign;
  logic             busy;
  logic             done;
  logic             div_ovf;
  logic [5:0]       ad_func;
  logic [1:0]       adb_sel;
  logic             ar_load;
  logic [1:0]       ar_shift;
  logic             arx_load;
  logic [1:0]       mq_sel;
  logic             mq_in;
  logic [2:0]       fsm_state;
`ifdef EDP_MDSEQ_STATS_EN
  logic [15:0]      stat_cycles;
  logic [15:0]      stat_ops;

  modport master (
    output start, op, steps, abort, mq35, ad_sign,
    input  busy, done, div_ovf, ad_func, adb_sel, ar_load, ar_shift,
           arx_load, mq_sel, mq_in, fsm_state, stat_cycles, stat_ops
  );
  modport slave (
    input  start, op, steps, abort, mq35, ad_sign,
    output busy, done, div_ovf, ad_func, adb_sel, ar_load, ar_shift,
           arx_load, mq_sel, mq_in, fsm_state, stat_cycles, stat_ops
  );
`else
  modport master (
    output start, op, steps, abort, mq35, ad_sign,
    input  busy, done, div_ovf, ad_func, adb_sel, ar_load, ar_shift,
           arx_load, mq_sel, mq_in, fsm_state
  );
  modport slave (
    input  start, op, steps, abort, mq35, ad_sign,
    output busy, done, div_ovf, ad_func, adb_sel, ar_load, ar_shift,
           arx_load, mq_sel, mq_in, fsm_state
  );
`endif
endinterface

// File: rtl/edp_mdseq.sv
// Radix-2 Booth multiply / non-restoring divide step sequencer for the EDP.
// Optional busy/done statistics counters are enabled by EDP_MDSEQ_STATS_EN.
module edp_mdseq #(
  parameter int         STEPW   = 6,
  parameter logic [5:0] AD_PASS = 6'o25,
  parameter logic [5:0] AD_ADD  = 6'o06,
  parameter logic [5:0] AD_SUB  = 6'o31,
  parameter logic [1:0] MQ_HOLD = 2'b00,
  parameter logic [1:0] MQ_SHR  = 2'b01,
  parameter logic [1:0] MQ_SHL  = 2'b10
) (
  input logic       clk,
  input logic       rst_n,
  edp_mdseq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_STEP  = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state;
  logic             op_r;
  logic [STEPW-1:0] cnt;
  logic             q_m1;
  logic             first;
  logic             div_ovf_r;
  logic             busy_c;
  logic             done_c;
  logic [5:0]       ad_func_c;
  logic             ar_load_c;
  logic [1:0]       ar_shift_c;
  logic             arx_load_c;
  logic [1:0]       mq_sel_c;
  logic             mq_in_c;
  logic             div_ovf_hit;

  assign busy_c      = (state != S_IDLE);
  assign done_c      = (state == S_DONE) && !bus.abort;
  assign div_ovf_hit = op_r && first && !bus.ad_sign;

  // q_m1 holds the previous Booth bit for MUL and the previous AD sign for DIV.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_r      <= 1'b0;
      cnt       <= '0;
      q_m1      <= 1'b0;
      first     <= 1'b0;
      div_ovf_r <= 1'b0;
    end else if (busy_c && bus.abort) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            state     <= S_SETUP;
            op_r      <= bus.op;
            cnt       <= bus.steps;
            q_m1      <= 1'b0;
            first     <= 1'b1;
            div_ovf_r <= 1'b0;
          end
        end
        S_SETUP: begin
          if (cnt == '0) state <= op_r ? S_FIXUP : S_DONE;
          else           state <= S_STEP;
        end
        S_STEP: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          first <= 1'b0;
          q_m1  <= op_r ? bus.ad_sign : bus.mq35;
          if (div_ovf_hit) begin
            div_ovf_r <= 1'b1;
            state     <= S_DONE;
          end else if (cnt <= STEPW'(1)) begin
            state <= op_r ? S_FIXUP : S_DONE;
          end
        end
        S_FIXUP: state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ad_func_c  = AD_PASS;
    ar_load_c  = 1'b0;
    ar_shift_c = 2'b00;
    arx_load_c = 1'b0;
    mq_sel_c   = MQ_HOLD;
    mq_in_c    = 1'b0;
    case (state)
      S_STEP: begin
        if (!op_r) begin
          case ({bus.mq35, q_m1})
            2'b10:   ad_func_c = AD_SUB;
            2'b01:   ad_func_c = AD_ADD;
            default: ad_func_c = AD_PASS;
          endcase
          ar_load_c  = 1'b1;
          ar_shift_c = 2'b01;
          arx_load_c = 1'b1;
          mq_sel_c   = MQ_SHR;
        end else begin
          ad_func_c  = (!first && q_m1) ? AD_ADD : AD_SUB;
          ar_load_c  = !div_ovf_hit;
          ar_shift_c = 2'b10;
          mq_sel_c   = MQ_SHL;
          mq_in_c    = !bus.ad_sign;
        end
      end
      // Negative remainder is restored by adding the divisor back once.
      S_FIXUP: begin
        ad_func_c = AD_ADD;
        ar_load_c = bus.ad_sign;
      end
      default: ;
    endcase
    if (busy_c && bus.abort) begin
      ar_load_c  = 1'b0;
      arx_load_c = 1'b0;
      mq_sel_c   = MQ_HOLD;
    end
  end

  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.div_ovf   = div_ovf_r;
  assign bus.ad_func   = ad_func_c;
  assign bus.adb_sel   = busy_c ? 2'b10 : 2'b00;
  assign bus.ar_load   = ar_load_c;
  assign bus.ar_shift  = ar_shift_c;
  assign bus.arx_load  = arx_load_c;
  assign bus.mq_sel    = mq_sel_c;
  assign bus.mq_in     = mq_in_c;
  assign bus.fsm_state = state;

`ifdef EDP_MDSEQ_STATS_EN
  logic [15:0] stat_cycles_r;
  logic [15:0] stat_ops_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cycles_r <= '0;
      stat_ops_r    <= '0;
    end else begin
      if (busy_c && (stat_cycles_r != 16'hFFFF)) stat_cycles_r <= stat_cycles_r + 16'd1;
      if (done_c && (stat_ops_r != 16'hFFFF))    stat_ops_r    <= stat_ops_r + 16'd1;
    end
  end

  assign bus.stat_cycles = stat_cycles_r;
  assign bus.stat_ops    = stat_ops_r;
`endif

endmodule

// File: tb/tb_edp_mdseq.sv
// Scoreboard bench for edp_mdseq: per-operation reference sequences are queued
// by the driver and popped by a monitor on every busy cycle.
module tb_edp_mdseq;

  localparam logic [5:0] PASS = 6'o25;
  localparam logic [5:0] ADD  = 6'o06;
  localparam logic [5:0] SUB  = 6'o31;
  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] SHR  = 2'b01;
  localparam logic [1:0] SHL  = 2'b10;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  bit   mq_v [0:63];
  bit   sg_v [0:63];
  logic [17:0] exp_q[$];

  edp_mdseq_if #(.STEPW(6)) bus ();

  edp_mdseq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  // {busy, done, div_ovf, ad_func, adb_sel, ar_load, ar_shift, arx_load, mq_sel, mq_in}
  function automatic logic [17:0] pack(bit bz, bit dn, bit ov, logic [5:0] f, bit arl,
                                       logic [1:0] ars, bit arx, logic [1:0] mqs, bit mqi);
    return {bz, dn, ov, f, (bz ? 2'b10 : 2'b00), arl, ars, arx, mqs, mqi};
  endfunction

  function automatic logic [17:0] act_word();
    return {bus.busy, bus.done, bus.div_ovf, bus.ad_func, bus.adb_sel, bus.ar_load,
            bus.ar_shift, bus.arx_load, bus.mq_sel, bus.mq_in};
  endfunction

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: act=%h req=%h", name, act, req);
    end
  endtask

  // Reference: expected control word for every busy cycle, k=0 being SETUP.
  task automatic model_op(input bit op, input int n, input int abort_at, input int stop_at,
                          output int len, output bit ovf);
    logic [17:0] seq[$];
    bit prev;
    logic [5:0] f;
    logic [17:0] e;
    ovf = 1'b0;
    seq.push_back(pack(1, 0, 0, PASS, 0, 2'b00, 0, HOLD, 0));
    if (!op) begin
      prev = 1'b0;
      for (int i = 0; i < n; i++) begin
        f = (mq_v[i+1] == prev) ? PASS : (mq_v[i+1] ? SUB : ADD);
        seq.push_back(pack(1, 0, 0, f, 1, 2'b01, 1, SHR, 0));
        prev = mq_v[i+1];
      end
    end else begin
      for (int i = 0; i < n; i++) begin
        if (i == 0 && !sg_v[1]) begin
          seq.push_back(pack(1, 0, 0, SUB, 0, 2'b10, 0, SHL, 1));
          ovf = 1'b1;
          break;
        end
        f = (i == 0 || !sg_v[i]) ? SUB : ADD;
        seq.push_back(pack(1, 0, 0, f, 1, 2'b10, 0, SHL, !sg_v[i+1]));
      end
      if (!ovf) seq.push_back(pack(1, 0, 0, ADD, sg_v[n+1], 2'b00, 0, HOLD, 0));
    end
    seq.push_back(pack(1, 1, ovf, PASS, 0, 2'b00, 0, HOLD, 0));
    if (abort_at >= 0 && abort_at < seq.size()) begin
      if (abort_at < seq.size() - 1) ovf = 1'b0;
      while (seq.size() > abort_at + 1) void'(seq.pop_back());
      e = seq.pop_back();
      e[16] = 1'b0;
      e[6] = 1'b0;
      e[3] = 1'b0;
      e[2:1] = HOLD;
      seq.push_back(e);
    end
    if (stop_at >= 0) begin
      ovf = 1'b0;
      while (seq.size() > stop_at) void'(seq.pop_back());
    end
    len = seq.size();
    foreach (seq[i]) exp_q.push_back(seq[i]);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 64; i++) begin
      mq_v[i] = 1'($urandom_range(0, 1));
      sg_v[i] = 1'($urandom_range(0, 1));
    end
  endtask

  // driver
  task automatic run_op(input bit opv, input int n, input int abort_at, input int rst_at);
    int len;
    bit ovf;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.op    = opv;
    bus.steps = 6'(n);
    bus.abort = 1'b0;
    model_op(opv, n, abort_at, rst_at, len, ovf);
    for (int k = 0; k < len; k++) begin
      @(posedge clk); #1;
      bus.start   = 1'($urandom_range(0, 1));
      bus.op      = 1'($urandom_range(0, 1));
      bus.steps   = 6'($urandom_range(0, 63));
      bus.mq35    = mq_v[k];
      bus.ad_sign = sg_v[k];
      bus.abort   = (k == abort_at);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    if (rst_at >= 0) begin
      #1 rst_n = 1'b0;
      #1 check("async_reset", act_word(), pack(0, 0, 0, PASS, 0, 2'b00, 0, HOLD, 0));
      @(posedge clk); #1;
      rst_n = 1'b1;
    end
    @(negedge clk);
    check("idle_after_op", {bus.busy, bus.done, bus.div_ovf}, {3'b000, 15'd0} >> 15 | 18'(ovf));
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_busy_cycles: act=%0d_left req=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.busy) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_busy: act=%h req=idle", act_word());
        end else begin
          n_cmp--;
          check("busy_cycle", act_word(), exp_q.pop_front());
        end
      end else if (bus.done) begin
        n_cmp++;
        n_err++;
        $display("FAIL done_while_idle: act=1 req=0");
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.op = 1'b0;
    bus.steps = '0;
    bus.abort = 1'b0;
    bus.mq35 = 1'b0;
    bus.ad_sign = 1'b0;
    repeat (2) @(posedge clk);
    #2 check("reset_state", act_word(), pack(0, 0, 0, PASS, 0, 2'b00, 0, HOLD, 0));
    @(posedge clk); #1;
    rst_n = 1'b1;

`ifdef EDP_MDSEQ_STATS_EN
    fill_rand();
    run_op(1'b0, 4, -1, -1);
    fill_rand();
    run_op(1'b0, 4, -1, -1);
    check("stat_ops", 18'(bus.stat_ops), 18'd2);
    check("stat_cycles", 18'(bus.stat_cycles), 18'd12);
`endif

    // MUL 4 steps, multiplier bits 1,0,1,1
    fill_rand();
    mq_v[1] = 1; mq_v[2] = 0; mq_v[3] = 1; mq_v[4] = 1;
    run_op(1'b0, 4, -1, -1);
    // DIV 3 steps, signs 1,0,1 then fixup sign 1
    fill_rand();
    sg_v[1] = 1; sg_v[2] = 0; sg_v[3] = 1; sg_v[4] = 1;
    run_op(1'b1, 3, -1, -1);
    // DIV overflow on first step; div_ovf must stay until the next start
    fill_rand();
    sg_v[1] = 0;
    run_op(1'b1, 5, -1, -1);
    repeat (3) @(negedge clk);
    check("div_ovf_held", 18'(bus.div_ovf), 18'd1);
    // MUL zero steps
    fill_rand();
    run_op(1'b0, 0, -1, -1);
    // DIV zero steps
    fill_rand();
    run_op(1'b1, 0, -1, -1);
    // MUL 8 steps aborted in the second STEP cycle
    fill_rand();
    run_op(1'b0, 8, 2, -1);
    // reset in the middle of a long DIV
    fill_rand();
    sg_v[1] = 1;
    run_op(1'b1, 10, -1, 4);

    for (int t = 0; t < 40; t++) begin
      int n;
      int ab;
      n = $urandom_range(0, 12);
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n + 2) : -1;
      fill_rand();
      if ($urandom_range(0, 3) != 0) sg_v[1] = 1;
      run_op(1'($urandom_range(0, 1)), n, ab, -1);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
